// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: function codes, FSM states, flag bit positions.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    F_ADD = 3'b000,
    F_SUB = 3'b001,
    F_NOT = 3'b010,
    F_AND = 3'b011,
    F_OR  = 3'b100,
    F_XOR = 3'b101,
    F_SLT = 3'b110,
    F_EQ  = 3'b111
  } func_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam int FLG_OV  = 3;
  localparam int FLG_C   = 2;
  localparam int FLG_Z   = 1;
  localparam int FLG_OUT = 0;

  // Only SLT/EQ drive a meaningful alu_out.
  function automatic logic is_cmp(input logic [2:0] func);
    return func[2] & func[1];
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Command, ALU and response signal bundle; slave is the sequencer, master is its environment.
interface alu_seq_if #(
  parameter int W = 4
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_li;
  logic [2:0]   cmd_func;
  logic [1:0]   cmd_rd;
  logic [1:0]   cmd_rs1;
  logic [1:0]   cmd_rs2;
  logic [W-1:0] cmd_imm;

  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_func;
  logic [W-1:0] alu_result;
  logic         alu_out;
  logic         alu_carry;
  logic         alu_zero;
  logic         alu_overflow;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic [3:0]   rsp_flags;

  modport master (
    output cmd_valid, cmd_li, cmd_func, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
    input  cmd_ready,
    input  alu_a, alu_b, alu_func,
    output alu_result, alu_out, alu_carry, alu_zero, alu_overflow,
    input  rsp_valid, rsp_data, rsp_flags,
    output rsp_ready
  );

  modport slave (
    input  cmd_valid, cmd_li, cmd_func, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
    output cmd_ready,
    output alu_a, alu_b, alu_func,
    input  alu_result, alu_out, alu_carry, alu_zero, alu_overflow,
    output rsp_valid, rsp_data, rsp_flags,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_seq_regfile.sv
// Register file: NREG x W, two combinational read ports, one write port.
// Latency: reads 0 cycles, write visible after the write edge.
// Backpressure: none; writes are unconditional when we is high.
module alu_seq_regfile #(
  parameter int NREG = 4,
  parameter int W    = 4,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr0,
  output logic [W-1:0]  rdata0,
  input  logic [AW-1:0] raddr1,
  output logic [W-1:0]  rdata1
);
  logic [W-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];
endmodule

// File: rtl/alu_seq.sv
// Command sequencer feeding an external 4-bit ALU and writing results back to a small register file.
// Latency: ALU op accept->rsp_valid 2 cycles, load-immediate 1 cycle.
// Backpressure: RESP holds until rsp_ready; cmd_ready follows rsp_ready while a response is pending.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int NREG = 4,
  parameter int W    = 4
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);
  localparam int AW = $clog2(NREG);

  state_e        state, state_nxt;
  logic          cmd_rdy, rsp_vld, accept;
  logic [AW-1:0] rd_q;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [W-1:0]  rf_wdata, rs1_dat, rs2_dat;
  logic [W-1:0]  exec_dat;
  logic [3:0]    exec_flags;

  assign accept        = bus.cmd_valid && cmd_rdy;
  assign bus.cmd_ready = cmd_rdy;
  assign bus.rsp_valid = rsp_vld;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_rdy   = 1'b0;
    rsp_vld   = 1'b0;
    unique case (state)
      S_IDLE: begin
        cmd_rdy = !rst;
        if (accept) state_nxt = bus.cmd_li ? S_RESP : S_EXEC;
      end
      S_EXEC: state_nxt = S_RESP;
      S_RESP: begin
        rsp_vld = 1'b1;
        cmd_rdy = !rst && bus.rsp_ready;
        if (bus.rsp_ready) begin
          if (accept) state_nxt = bus.cmd_li ? S_RESP : S_EXEC;
          else        state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // alu_out is only meaningful for compares; mask it everywhere else.
  always_comb begin
    exec_flags          = '0;
    exec_flags[FLG_OV]  = bus.alu_overflow;
    exec_flags[FLG_C]   = bus.alu_carry;
    exec_flags[FLG_Z]   = bus.alu_zero;
    exec_flags[FLG_OUT] = is_cmp(bus.alu_func) & bus.alu_out;
    exec_dat = is_cmp(bus.alu_func) ? {{(W-1){1'b0}}, bus.alu_out} : bus.alu_result;
  end

  // EXEC write-back and LI accept are mutually exclusive: cmd_ready is low in EXEC.
  assign rf_we    = (state == S_EXEC) || (accept && bus.cmd_li);
  assign rf_waddr = (state == S_EXEC) ? rd_q : bus.cmd_rd;
  assign rf_wdata = (state == S_EXEC) ? exec_dat : bus.cmd_imm;

  alu_seq_regfile #(.NREG(NREG), .W(W)) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata),
    .raddr0 (bus.cmd_rs1),
    .rdata0 (rs1_dat),
    .raddr1 (bus.cmd_rs2),
    .rdata1 (rs2_dat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.alu_func  <= '0;
      rd_q          <= '0;
      bus.rsp_data  <= '0;
      bus.rsp_flags <= '0;
    end else begin
      if (accept && !bus.cmd_li) begin
        bus.alu_a    <= rs1_dat;
        bus.alu_b    <= rs2_dat;
        bus.alu_func <= bus.cmd_func;
        rd_q         <= bus.cmd_rd;
      end
      if (accept && bus.cmd_li) begin
        bus.rsp_data  <= bus.cmd_imm;
        bus.rsp_flags <= '0;
      end
      if (state == S_EXEC) begin
        bus.rsp_data  <= exec_dat;
        bus.rsp_flags <= exec_flags;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: bit-level ALU stand-in, directed vector table, corner sequences, randomized model check.
module tb_alu_seq;
  import alu_seq_pkg::*;

  typedef struct {
    logic       li;
    logic [2:0] func;
    logic [1:0] rd, rs1, rs2;
    logic [3:0] imm, dat, flags;
  } vec_t;

  typedef struct {
    logic [3:0] dat;
    logic [3:0] flags;
    longint     t;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic garbage = 1'b0;
  int   total = 0;
  int   bad = 0;
  rsp_t rsp_q[$];
  vec_t tbl[16];

  alu_seq_if #(.W(4)) bus ();

  alu_seq #(.NREG(4), .W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  always @(posedge clk) garbage <= 1'($urandom);

  // Stand-in for the external ALU, combinational on the registered operands.
  logic [4:0] s;
  logic [3:0] res;
  always_comb begin
    s = '0;
    res = '0;
    bus.alu_carry = 1'b0;
    bus.alu_overflow = 1'b0;
    bus.alu_out = garbage;
    case (bus.alu_func)
      3'b000: begin
        s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        res = s[3:0];
        bus.alu_carry = s[4];
        bus.alu_overflow = (bus.alu_a[3] == bus.alu_b[3]) && (res[3] != bus.alu_a[3]);
      end
      3'b010: res = ~bus.alu_a;
      3'b011: res = bus.alu_a & bus.alu_b;
      3'b100: res = bus.alu_a | bus.alu_b;
      3'b101: res = bus.alu_a ^ bus.alu_b;
      default: begin
        s = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 5'd1;
        res = s[3:0];
        bus.alu_carry = s[4];
        bus.alu_overflow = (bus.alu_a[3] != bus.alu_b[3]) && (res[3] != bus.alu_a[3]);
      end
    endcase
    if (bus.alu_func == 3'b110) bus.alu_out = res[3] ^ bus.alu_overflow;
    if (bus.alu_func == 3'b111) bus.alu_out = (res == 4'd0);
    bus.alu_result = res;
    bus.alu_zero = (res == 4'd0);
  end

  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready)
      rsp_q.push_back('{bus.rsp_data, bus.rsp_flags, longint'($time)});
  end

  function automatic vec_t mk(int li, int f, int rd, int rs1, int rs2, int imm, int d, int fl);
    vec_t v;
    v.li = 1'(li); v.func = 3'(f); v.rd = 2'(rd); v.rs1 = 2'(rs1); v.rs2 = 2'(rs2);
    v.imm = 4'(imm); v.dat = 4'(d); v.flags = 4'(fl);
    return v;
  endfunction

  // Reference: integer arithmetic on unsigned/signed interpretations; returns {data, flags}.
  function automatic logic [7:0] model_op(int f, logic [3:0] a, logic [3:0] b);
    int ua = int'(a), ub = int'(b);
    int sa = a[3] ? ua - 16 : ua;
    int sb = b[3] ? ub - 16 : ub;
    int r = 0, sr = 0;
    bit c = 0, ov = 0, o = 0;
    logic [3:0] v;
    case (f)
      0: begin r = ua + ub; sr = sa + sb; c = (r > 15); ov = (sr > 7) || (sr < -8); end
      2: r = int'(~a);
      3: r = int'(a & b);
      4: r = int'(a | b);
      5: r = int'(a ^ b);
      default: begin r = ua - ub; sr = sa - sb; c = (ua >= ub); ov = (sr > 7) || (sr < -8); end
    endcase
    v = 4'(r);
    if (f == 6) o = (sa < sb);
    if (f == 7) o = (ua == ub);
    return {(f >= 6) ? {3'b000, o} : v, ov, c, (v == 4'd0), o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int li, input int f, input int rd, input int rs1, input int rs2,
                       input int imm, output longint ta);
    bus.cmd_li = 1'(li); bus.cmd_func = 3'(f); bus.cmd_rd = 2'(rd);
    bus.cmd_rs1 = 2'(rs1); bus.cmd_rs2 = 2'(rs2); bus.cmd_imm = 4'(imm);
    bus.cmd_valid = 1'b1;
    ta = -1;
    for (int k = 0; k < 50 && ta < 0; k++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        @(posedge clk);
        ta = longint'($time);
        #1;
      end else begin
        cyc();
      end
    end
    bus.cmd_valid = 1'b0;
    if (ta < 0) note_fail("accept");
  endtask

  task automatic get_rsp(output rsp_t r);
    bit got = 0;
    r = '{4'd0, 4'd0, 0};
    for (int k = 0; k < 40 && !got; k++) begin
      if (rsp_q.size() > 0) begin
        r = rsp_q.pop_front();
        got = 1;
      end else begin
        cyc();
      end
    end
    if (!got) note_fail("response");
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    longint ta;
    rsp_t r;
    issue(int'(v.li), int'(v.func), int'(v.rd), int'(v.rs1), int'(v.rs2), int'(v.imm), ta);
    get_rsp(r);
    chk($sformatf("vec%0d_data", idx), 32'(r.dat), 32'(v.dat));
    chk($sformatf("vec%0d_flags", idx), 32'(r.flags), 32'(v.flags));
    chk($sformatf("vec%0d_latency", idx), 32'(r.t - ta), v.li ? 32'd5 : 32'd15);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
    rsp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint ta;
    longint tacc[5];
    rsp_t   r;
    rsp_t   rs[5];
    logic [3:0] m[4];
    logic [7:0] e;

    tbl[0]  = mk(1, 0, 1, 0, 0, 5, 5, 4'b0000);
    tbl[1]  = mk(1, 0, 2, 0, 0, 3, 3, 4'b0000);
    tbl[2]  = mk(0, F_ADD, 3, 1, 2, 0, 8, 4'b1000);
    tbl[3]  = mk(0, F_OR, 0, 3, 3, 0, 8, 4'b0000);
    tbl[4]  = mk(0, F_SUB, 0, 1, 1, 0, 0, 4'b0110);
    tbl[5]  = mk(1, 0, 1, 0, 0, 14, 14, 4'b0000);
    tbl[6]  = mk(1, 0, 2, 0, 0, 3, 3, 4'b0000);
    tbl[7]  = mk(0, F_SLT, 3, 1, 2, 0, 1, 4'b0101);
    tbl[8]  = mk(0, F_EQ, 3, 1, 1, 0, 1, 4'b0111);
    tbl[9]  = mk(0, F_NOT, 0, 2, 0, 0, 12, 4'b0000);
    tbl[10] = mk(0, F_XOR, 1, 1, 2, 0, 13, 4'b0000);
    tbl[11] = mk(0, F_OR, 0, 1, 1, 0, 13, 4'b0000);
    tbl[12] = mk(1, 0, 0, 0, 0, 15, 15, 4'b0000);
    tbl[13] = mk(0, F_ADD, 0, 0, 1, 0, 12, 4'b0100);
    tbl[14] = mk(0, F_AND, 2, 0, 1, 0, 12, 4'b0000);
    tbl[15] = mk(0, F_SUB, 3, 2, 1, 0, 15, 4'b0000);

    bus.cmd_valid = 1'b0; bus.cmd_li = 1'b0; bus.cmd_func = '0; bus.cmd_rd = '0;
    bus.cmd_rs1 = '0; bus.cmd_rs2 = '0; bus.cmd_imm = '0; bus.rsp_ready = 1'b1;
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_alu_a", 32'(bus.alu_a), 0);
    chk("rst_alu_b", 32'(bus.alu_b), 0);
    chk("rst_alu_func", 32'(bus.alu_func), 0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 0);
    chk("rst_rsp_flags", 32'(bus.rsp_flags), 0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 1);
    cyc();

    for (int i = 0; i < 16; i++) run_vec(tbl[i], i);

    // Response stall with a new command waiting, then release.
    issue(1, 0, 1, 0, 0, 9, ta);
    bus.rsp_ready = 1'b0;
    bus.cmd_li = 1'b1; bus.cmd_rd = 2'd2; bus.cmd_imm = 4'd6; bus.cmd_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_valid", k), 32'(bus.rsp_valid), 1);
      chk($sformatf("stall%0d_data", k), 32'(bus.rsp_data), 9);
      chk($sformatf("stall%0d_flags", k), 32'(bus.rsp_flags), 0);
      chk($sformatf("stall%0d_cmd_ready", k), 32'(bus.cmd_ready), 0);
      cyc();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("release_cmd_ready", 32'(bus.cmd_ready), 1);
    cyc();
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("release_next_valid", 32'(bus.rsp_valid), 1);
    chk("release_next_data", 32'(bus.rsp_data), 6);
    cyc();
    chk("release_rsp_count", 32'(rsp_q.size()), 2);
    get_rsp(r);
    chk("release_first", 32'(r.dat), 9);
    get_rsp(r);
    chk("release_second", 32'(r.dat), 6);

    // Reset while the ADD sits in EXEC.
    issue(1, 0, 1, 0, 0, 7, ta);
    get_rsp(r);
    issue(0, F_ADD, 2, 1, 1, 0, ta);
    rst = 1'b1;
    cyc();
    @(negedge clk);
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("abort_rsp_data", 32'(bus.rsp_data), 0);
    chk("abort_rsp_flags", 32'(bus.rsp_flags), 0);
    chk("abort_alu_a", 32'(bus.alu_a), 0);
    chk("abort_alu_func", 32'(bus.alu_func), 0);
    chk("abort_cmd_ready", 32'(bus.cmd_ready), 0);
    chk("abort_no_rsp", 32'(rsp_q.size()), 0);
    cyc();
    rst = 1'b0;
    rsp_q.delete();
    run_vec(mk(0, F_OR, 0, 2, 2, 0, 0, 4'b0010), 100);
    run_vec(mk(0, F_OR, 0, 1, 1, 0, 0, 4'b0010), 101);

    // Back-to-back: two LIs then XOR/AND/OR with cmd_valid never dropping.
    issue(1, 0, 1, 0, 0, 10, tacc[0]);
    issue(1, 0, 2, 0, 0, 6, tacc[1]);
    issue(0, F_XOR, 3, 1, 2, 0, tacc[2]);
    issue(0, F_AND, 0, 1, 2, 0, tacc[3]);
    issue(0, F_OR, 3, 1, 2, 0, tacc[4]);
    for (int k = 0; k < 5; k++) get_rsp(rs[k]);
    chk("b2b_li_gap", 32'(tacc[1] - tacc[0]), 10);
    chk("b2b_op_gap0", 32'(tacc[3] - tacc[2]), 20);
    chk("b2b_op_gap1", 32'(tacc[4] - tacc[3]), 20);
    chk("b2b_rsp_gap0", 32'(rs[3].t - rs[2].t), 20);
    chk("b2b_rsp_gap1", 32'(rs[4].t - rs[3].t), 20);
    chk("b2b_xor", 32'({rs[2].dat, rs[2].flags}), 32'h0c0);
    chk("b2b_and", 32'({rs[3].dat, rs[3].flags}), 32'h020);
    chk("b2b_or", 32'({rs[4].dat, rs[4].flags}), 32'h0e0);

    // Randomized commands against the integer reference model, with random response stalls.
    do_reset();
    for (int i = 0; i < 4; i++) m[i] = 4'd0;
    for (int i = 0; i < 80; i++) begin
      int li, f, rd, rs1, rs2, imm, k;
      li = ($urandom_range(0, 3) == 0) ? 1 : 0;
      f = int'($urandom_range(0, 7));
      rd = int'($urandom_range(0, 3));
      rs1 = int'($urandom_range(0, 3));
      rs2 = int'($urandom_range(0, 3));
      imm = int'($urandom_range(0, 15));
      if (li == 1) e = {4'(imm), 4'b0000};
      else         e = model_op(f, m[rs1], m[rs2]);
      m[rd] = e[7:4];
      issue(li, f, rd, rs1, rs2, imm, ta);
      k = int'($urandom_range(0, 2));
      if (k > 0) begin
        bus.rsp_ready = 1'b0;
        repeat (k) cyc();
        bus.rsp_ready = 1'b1;
      end
      get_rsp(r);
      chk($sformatf("rand%0d_data", i), 32'(r.dat), 32'(e[7:4]));
      chk($sformatf("rand%0d_flags", i), 32'(r.flags), 32'(e[3:0]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
